// File: rtl/prbs_checker.sv
// Receive-side checker for the Galois-LFSR PRBS stream.
// Self-synchronises from the data, then counts mismatching words.
module prbs_checker #(
   parameter int WIDTH       = 16,
   parameter int LOCK_COUNT  = 16,
   parameter int UNLOCK_ERRS = 8,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic [WIDTH-1:0] din,
   input  logic             din_valid,
   input  logic             clear,
   output logic             locked,
   output logic             error,
   output logic [CNT_W-1:0] err_count,
   output logic [CNT_W-1:0] word_count
);

   localparam int MC_W = $clog2(LOCK_COUNT + 1);
   localparam int UE_W = $clog2(UNLOCK_ERRS + 1);
   localparam logic [MC_W-1:0] LC_LAST = MC_W'(LOCK_COUNT - 1);
   localparam logic [UE_W-1:0] UE_LAST = UE_W'(UNLOCK_ERRS - 1);

   function automatic logic [63:0] bit_of(input int n);
      return (n > 0) ? (64'd1 << (n - 1)) : 64'd0;
   endfunction

   function automatic logic [63:0] t4(input int a, input int b,
                                      input int c, input int d);
      return bit_of(a) | bit_of(b) | bit_of(c) | bit_of(d);
   endfunction

   // Galois feedback masks built from the XAPP052 tap positions
   function automatic logic [63:0] tap_mask(input int w);
      logic [63:0] m;
      case (w)
         3:  m = t4(3, 2, 0, 0);
         4:  m = t4(4, 3, 0, 0);
         5:  m = t4(5, 3, 0, 0);
         6:  m = t4(6, 5, 0, 0);
         7:  m = t4(7, 6, 0, 0);
         8:  m = t4(8, 6, 5, 4);
         9:  m = t4(9, 5, 0, 0);
         10: m = t4(10, 7, 0, 0);
         11: m = t4(11, 9, 0, 0);
         12: m = t4(12, 6, 4, 1);
         13: m = t4(13, 4, 3, 1);
         14: m = t4(14, 5, 3, 1);
         15: m = t4(15, 14, 0, 0);
         16: m = t4(16, 15, 13, 4);
         17: m = t4(17, 14, 0, 0);
         18: m = t4(18, 11, 0, 0);
         19: m = t4(19, 6, 2, 1);
         20: m = t4(20, 17, 0, 0);
         21: m = t4(21, 19, 0, 0);
         22: m = t4(22, 21, 0, 0);
         23: m = t4(23, 18, 0, 0);
         24: m = t4(24, 23, 22, 17);
         25: m = t4(25, 22, 0, 0);
         26: m = t4(26, 6, 2, 1);
         27: m = t4(27, 5, 2, 1);
         28: m = t4(28, 25, 0, 0);
         29: m = t4(29, 27, 0, 0);
         30: m = t4(30, 6, 4, 1);
         31: m = t4(31, 28, 0, 0);
         32: m = t4(32, 22, 2, 1);
         33: m = t4(33, 20, 0, 0);
         34: m = t4(34, 27, 2, 1);
         35: m = t4(35, 33, 0, 0);
         36: m = t4(36, 25, 0, 0);
         37: m = t4(37, 5, 4, 3) | t4(2, 1, 0, 0);
         38: m = t4(38, 6, 5, 1);
         39: m = t4(39, 35, 0, 0);
         40: m = t4(40, 38, 21, 19);
         41: m = t4(41, 38, 0, 0);
         42: m = t4(42, 41, 20, 19);
         43: m = t4(43, 42, 38, 37);
         44: m = t4(44, 43, 18, 17);
         45: m = t4(45, 44, 42, 41);
         46: m = t4(46, 45, 26, 25);
         47: m = t4(47, 42, 0, 0);
         48: m = t4(48, 47, 21, 20);
         49: m = t4(49, 40, 0, 0);
         50: m = t4(50, 49, 24, 23);
         51: m = t4(51, 50, 36, 35);
         52: m = t4(52, 49, 0, 0);
         53: m = t4(53, 52, 38, 37);
         54: m = t4(54, 53, 18, 17);
         55: m = t4(55, 31, 0, 0);
         56: m = t4(56, 55, 35, 34);
         57: m = t4(57, 50, 0, 0);
         58: m = t4(58, 39, 0, 0);
         59: m = t4(59, 58, 38, 37);
         60: m = t4(60, 59, 0, 0);
         61: m = t4(61, 60, 46, 45);
         62: m = t4(62, 61, 6, 5);
         63: m = t4(63, 62, 0, 0);
         64: m = t4(64, 63, 61, 60);
         default: m = t4(16, 15, 13, 4);
      endcase
      return m;
   endfunction

   localparam logic [63:0]      TAPS64 = tap_mask(WIDTH);
   localparam logic [WIDTH-1:0] TAPS   = TAPS64[WIDTH-1:0];

   function automatic logic [WIDTH-1:0] nxt(input logic [WIDTH-1:0] x);
      return (x >> 1) ^ (x[0] ? TAPS : '0);
   endfunction

   typedef enum logic {SEARCH, LOCKED} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] prev_q, prev_d;
   logic [WIDTH-1:0] exp_q, exp_d;
   logic [MC_W-1:0]  match_q, match_d;
   logic [UE_W-1:0]  bad_q, bad_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] ecnt_q, ecnt_d;
   logic [CNT_W-1:0] wcnt_q, wcnt_d;

   // prev resets to zero and next(0)==0, so the first sample cannot match
   always_comb begin
      state_d = state_q;
      prev_d  = prev_q;
      exp_d   = exp_q;
      match_d = match_q;
      bad_d   = bad_q;
      err_d   = 1'b0;
      ecnt_d  = ecnt_q;
      wcnt_d  = wcnt_q;
      if (din_valid) begin
         unique case (state_q)
            SEARCH: begin
               prev_d = din;
               if (din == nxt(prev_q) && din != '0) begin
                  if (match_q == LC_LAST) begin
                     state_d = LOCKED;
                     exp_d   = nxt(din);
                     match_d = '0;
                     bad_d   = '0;
                  end else begin
                     match_d = match_q + 1'b1;
                  end
               end else begin
                  match_d = '0;
               end
            end
            LOCKED: begin
               exp_d = nxt(exp_q);
               if (wcnt_q != '1) wcnt_d = wcnt_q + 1'b1;
               if (din != exp_q) begin
                  err_d = 1'b1;
                  if (ecnt_q != '1) ecnt_d = ecnt_q + 1'b1;
                  if (bad_q == UE_LAST) begin
                     state_d = SEARCH;
                     match_d = '0;
                     prev_d  = din;
                     bad_d   = '0;
                  end else begin
                     bad_d = bad_q + 1'b1;
                  end
               end else begin
                  bad_d = '0;
               end
            end
            default: state_d = SEARCH;
         endcase
      end
      if (clear) begin
         ecnt_d = '0;
         wcnt_d = '0;
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= SEARCH;
         prev_q  <= '0;
         exp_q   <= '0;
         match_q <= '0;
         bad_q   <= '0;
         err_q   <= 1'b0;
         ecnt_q  <= '0;
         wcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         prev_q  <= prev_d;
         exp_q   <= exp_d;
         match_q <= match_d;
         bad_q   <= bad_d;
         err_q   <= err_d;
         ecnt_q  <= ecnt_d;
         wcnt_q  <= wcnt_d;
      end
   end

   assign locked     = (state_q == LOCKED);
   assign error      = err_q;
   assign err_count  = ecnt_q;
   assign word_count = wcnt_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Randomised bench for prbs_checker against a sequence-level model.
// A second instance with 4-bit counters exercises saturation.
module tb_prbs_checker;

   localparam int LC = 16;
   localparam int UE = 8;
   localparam logic [15:0] TAPS = 16'hD008;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic [15:0] din = '0;
   logic        din_valid = 1'b0;
   logic        clear = 1'b0;
   logic        locked, error, locked_s, error_s;
   logic [31:0] err_count, word_count;
   logic [3:0]  err_count_s, word_count_s;

   prbs_checker #(.WIDTH(16), .LOCK_COUNT(LC), .UNLOCK_ERRS(UE),
                  .CNT_W(32)) dut (
      .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
      .clear(clear), .locked(locked), .error(error),
      .err_count(err_count), .word_count(word_count));

   prbs_checker #(.WIDTH(16), .LOCK_COUNT(LC), .UNLOCK_ERRS(UE),
                  .CNT_W(4)) dut_s (
      .clk(clk), .resetn(resetn), .din(din), .din_valid(din_valid),
      .clear(clear), .locked(locked_s), .error(error_s),
      .err_count(err_count_s), .word_count(word_count_s));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string tag, input logic [63:0] got,
                        input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [15:0] gnext(input logic [15:0] x);
      return (x >> 1) ^ (x[0] ? TAPS : 16'h0);
   endfunction

   // model: lock when the last LC+1 samples form an unbroken nonzero chain;
   // unlock when the last UE locked comparisons all failed
   bit          m_lock, m_err;
   longint      m_ecnt, m_wcnt;
   logic [15:0] m_exp;
   logic [15:0] hist[$];
   bit          res[$];

   task automatic model_reset();
      m_lock = 0; m_err = 0; m_ecnt = 0; m_wcnt = 0; m_exp = '0;
      hist.delete();
      res.delete();
   endtask

   task automatic model(input bit v, input logic [15:0] d, input bit c);
      bit ok, mism, all_bad;
      m_err = 0;
      if (v && !m_lock) begin
         hist.push_back(d);
         if (hist.size() > LC + 1) void'(hist.pop_front());
         if (hist.size() == LC + 1) begin
            ok = 1;
            for (int i = 1; i <= LC; i++)
               if (hist[i] != gnext(hist[i-1]) || hist[i] == 0) ok = 0;
            if (ok) begin
               m_lock = 1;
               m_exp = gnext(d);
               res.delete();
            end
         end
      end else if (v) begin
         m_wcnt++;
         mism = (d != m_exp);
         m_exp = gnext(m_exp);
         if (mism) begin
            m_err = 1;
            m_ecnt++;
         end
         res.push_back(mism);
         if (res.size() > UE) void'(res.pop_front());
         all_bad = (res.size() == UE);
         foreach (res[i]) if (!res[i]) all_bad = 0;
         if (all_bad) begin
            m_lock = 0;
            hist.delete();
            hist.push_back(d);
         end
      end
      if (c) begin
         m_ecnt = 0;
         m_wcnt = 0;
      end
   endtask

   function automatic longint sat4(input longint x);
      return (x > 15) ? 15 : x;
   endfunction

   task automatic compare_all();
      check("locked", locked, m_lock);
      check("error", error, m_err);
      check("err_count", err_count, m_ecnt);
      check("word_count", word_count, m_wcnt);
      check("sat_err_count", err_count_s, sat4(m_ecnt));
      check("sat_word_count", word_count_s, sat4(m_wcnt));
   endtask

   task automatic cycle(input bit v, input logic [15:0] d, input bit c);
      din_valid = v;
      din = d;
      clear = c;
      @(posedge clk);
      model(v, d, c);
      #1;
      compare_all();
   endtask

   task automatic do_reset();
      din_valid = 0;
      clear = 0;
      resetn = 0;
      model_reset();
      #1;
      compare_all();
      @(posedge clk);
      @(negedge clk);
      resetn = 1;
   endtask

   logic [15:0] g;
   logic [15:0] r;

   initial begin
      do_reset();

      // 1: clean stream from seed 0001
      g = 16'h0001;
      for (int i = 0; i < 100; i++) begin
         cycle(1, g, 0);
         if (i == 15) check("t1_prelock", locked, 0);
         if (i == 16) check("t1_lock", locked, 1);
         g = gnext(g);
      end
      check("t1_errs", err_count, 0);
      check("t1_words", word_count, 83);

      // 2: single flipped bit
      cycle(1, g ^ 16'h0001, 0);
      g = gnext(g);
      check("t2_err", error, 1);
      check("t2_cnt", err_count, 1);
      check("t2_lock", locked, 1);
      for (int i = 0; i < 10; i++) begin
         cycle(1, g, 0);
         g = gnext(g);
      end
      check("t2_quiet", error, 0);

      // 3: eight corrupt words then resync
      for (int i = 0; i < UE; i++) begin
         r = 16'($urandom_range(1, 16'hFFFF));
         cycle(1, g ^ r, 0);
         g = gnext(g);
      end
      check("t3_errs", err_count, 9);
      check("t3_unlock", locked, 0);
      for (int i = 0; i < 17; i++) begin
         cycle(1, g, 0);
         if (i == 15) check("t3_prelock", locked, 0);
         g = gnext(g);
      end
      check("t3_relock", locked, 1);

      // 4: all-zero input never locks
      do_reset();
      for (int i = 0; i < 200; i++) cycle(1, 16'h0000, 0);
      check("t4_lock", locked, 0);
      check("t4_words", word_count, 0);

      // 5: gapped stream with garbage on invalid cycles
      do_reset();
      g = 16'h0001;
      for (int i = 0; i < 100; i++) begin
         cycle(0, 16'($urandom), 0);
         cycle(0, 16'($urandom), 0);
         cycle(1, g, 0);
         if (i == 15) check("t5_prelock", locked, 0);
         if (i == 16) check("t5_lock", locked, 1);
         g = gnext(g);
      end
      check("t5_words", word_count, 83);
      cycle(1, g ^ 16'h0100, 1);
      g = gnext(g);
      check("t5_clr_err", error, 1);
      check("t5_clr_cnt", err_count, 0);

      // 6: asynchronous reset while locked
      do_reset();
      g = 16'h0001;
      for (int i = 0; i < 20; i++) begin
         cycle(1, g, 0);
         g = gnext(g);
      end
      for (int i = 0; i < 5; i++) begin
         cycle(1, g ^ 16'h8000, 0);
         g = gnext(g);
         cycle(1, g, 0);
         g = gnext(g);
      end
      check("t6_pre", err_count, 5);
      #2;
      resetn = 0;
      model_reset();
      #1;
      check("t6_lock", locked, 0);
      check("t6_cnt", err_count, 0);
      @(negedge clk);
      resetn = 1;
      for (int i = 0; i < 17; i++) begin
         cycle(1, g, 0);
         if (i == 15) check("t6_prelock", locked, 0);
         g = gnext(g);
      end
      check("t6_relock", locked, 1);

      // random: gaps, error bursts, clears
      for (int i = 0; i < 3000; i++) begin
         bit v, c;
         int burst;
         v = ($urandom_range(0, 3) != 0);
         c = ($urandom_range(0, 99) == 0);
         burst = ($urandom_range(0, 199) == 0) ? $urandom_range(6, 10) : 0;
         if (burst > 0) begin
            for (int k = 0; k < burst; k++) begin
               r = 16'($urandom_range(1, 16'hFFFF));
               cycle(1, g ^ r, 0);
               g = gnext(g);
            end
         end else if (v) begin
            r = ($urandom_range(0, 29) == 0) ? 16'($urandom_range(1, 16'hFFFF))
                                             : 16'h0000;
            cycle(1, g ^ r, c);
            g = gnext(g);
         end else begin
            cycle(0, 16'($urandom), c);
         end
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
